// File: rtl/dbuf_pkg.sv
// Shared definitions for the double-buffer stream writer.
//
// Contents:
//   wr_state_e  - writer FSM encoding (FILL fills the write bank, SWAP waits
//                 for the read bank to be free before swapping)
//   LEN_WIDTH   - width of frame lengths (bank address width + 1)
//   clamp_len   - maps a requested frame length to a legal one
//
// Optional feature macro used by the writer: DBUF_WR_STALL_CNT_EN.

package dbuf_pkg;

    localparam int BANK_ADDR_WIDTH_DEFAULT = 7;
    localparam int LEN_WIDTH               = BANK_ADDR_WIDTH_DEFAULT + 1;

    typedef enum logic {
        FILL = 1'b0,
        SWAP = 1'b1
    } wr_state_e;

    // A zero length or a length larger than a bank both mean "a full bank".
    function automatic int clamp_len(input int x, input int depth);
        if (x == 0 || x > depth) begin
            return depth;
        end
        return x;
    endfunction

endpackage

// File: rtl/dbuf_wr_addr_ctr.sv
// Write-address counter for the stream writer.
//
// Holds the word index inside the current frame (cnt) and the frame length
// latched at the last load point (len).
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset (acts as a load)
//   cfg_len   - requested frame length, clamped when loaded
//   load      - restart the frame: cnt=0, len=clamp(cfg_len)
//   inc       - a word was accepted; advance unless on the last word
//   cnt       - index of the next word to be written
//   len       - current frame length (1..BANK_DEPTH)
//   last      - cnt is the final word of the frame

module dbuf_wr_addr_ctr
    import dbuf_pkg::*;
#(
    parameter int BANK_ADDR_WIDTH = 7,
    parameter int BANK_DEPTH      = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [BANK_ADDR_WIDTH:0] cfg_len,
    input  logic                     load,
    input  logic                     inc,
    output logic [BANK_ADDR_WIDTH:0] cnt,
    output logic [BANK_ADDR_WIDTH:0] len,
    output logic                     last
);

    localparam int LW = BANK_ADDR_WIDTH + 1;

    logic [LW-1:0] cfg_clamped;

    assign cfg_clamped = LW'(clamp_len(int'(cfg_len), BANK_DEPTH));

    // len is never 0, so len-1 cannot wrap.
    assign last = (cnt == len - LW'(1));

    // On the last word cnt holds at len-1; the frame is closed by the
    // writer's SWAP state, which reloads through 'load'.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            cnt <= '0;
            len <= cfg_clamped;
        end else if (inc && !last) begin
            cnt <= cnt + LW'(1);
        end
    end

endmodule

// File: rtl/dbuf_stream_writer.sv
// Producer stage of the double buffer.
//
// Accepts a valid/ready word stream, writes each word to sequential
// addresses of the current write bank and, once a full frame is written,
// pulses switch_banks so the consumer can read it. A frame waits in SWAP
// while the read bank still holds an unconsumed frame, back-pressuring the
// stream so nothing is overwritten.
//
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   cfg_len       - frame length in words, sampled at reset and at each swap
//   s_valid/s_ready/s_data - input word stream
//   wen/wadr/wdata         - registered double-buffer write port
//   switch_banks  - one-cycle bank swap pulse
//   frame_valid   - read bank holds an unconsumed frame
//   frame_len     - length of the frame in the read bank
//   rd_done       - consumer finished the read bank
//   stall_cnt     - cycles with s_valid=1 and s_ready=0, saturating
//                   (present only when DBUF_WR_STALL_CNT_EN is defined)
//   dbg_state     - current FSM state, for observation only
//
// Build option: define DBUF_WR_STALL_CNT_EN to add the stall_cnt output.

module dbuf_stream_writer
    import dbuf_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int BANK_ADDR_WIDTH = 7,
    parameter int BANK_DEPTH      = 128
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [BANK_ADDR_WIDTH:0]   cfg_len,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [DATA_WIDTH-1:0]      s_data,
    output logic                       wen,
    output logic [BANK_ADDR_WIDTH-1:0] wadr,
    output logic [DATA_WIDTH-1:0]      wdata,
    output logic                       switch_banks,
    output logic                       frame_valid,
    output logic [BANK_ADDR_WIDTH:0]   frame_len,
    input  logic                       rd_done,
`ifdef DBUF_WR_STALL_CNT_EN
    output logic [15:0]                stall_cnt,
`endif
    output wr_state_e                  dbg_state
);

    wr_state_e                state;
    logic [BANK_ADDR_WIDTH:0] cnt;
    logic [BANK_ADDR_WIDTH:0] len;
    logic                     last;
    logic                     accept;
    logic                     swap_go;

    // Stream handshake: a word transfers on a rising edge where s_valid and
    // s_ready are both high. s_ready depends only on state and rst, never on
    // s_valid, and the producer must hold s_valid/s_data until the transfer.
    assign s_ready   = (state == FILL) && !rst;
    assign accept    = s_valid && s_ready;

    // The read bank is free when it is empty or is being released this cycle.
    assign swap_go   = (state == SWAP) && (!frame_valid || rd_done);

    assign dbg_state = state;

    dbuf_wr_addr_ctr #(
        .BANK_ADDR_WIDTH (BANK_ADDR_WIDTH),
        .BANK_DEPTH      (BANK_DEPTH)
    ) u_addr_ctr (
        .clk     (clk),
        .rst     (rst),
        .cfg_len (cfg_len),
        .load    (swap_go),
        .inc     (accept),
        .cnt     (cnt),
        .len     (len),
        .last    (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FILL;
            wen          <= 1'b0;
            wadr         <= '0;
            wdata        <= '0;
            switch_banks <= 1'b0;
            frame_valid  <= 1'b0;
            frame_len    <= '0;
        end else begin
            wen          <= accept;
            switch_banks <= 1'b0;

            // Address/data only move with a write; otherwise they hold.
            if (accept) begin
                wadr  <= cnt[BANK_ADDR_WIDTH-1:0];
                wdata <= s_data;
            end

            if (state == FILL) begin
                if (accept && last) begin
                    state <= SWAP;
                end
            end else begin
                // Leaving FILL takes one edge, so the pulse always trails the
                // frame's last write by at least one cycle.
                if (swap_go) begin
                    state        <= FILL;
                    switch_banks <= 1'b1;
                    frame_valid  <= 1'b1;
                    frame_len    <= len;
                end
            end

            // A swap in the same cycle refills the read bank, so it wins.
            if (rd_done && frame_valid && !swap_go) begin
                frame_valid <= 1'b0;
            end
        end
    end

`ifdef DBUF_WR_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (s_valid && !s_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`else
    // Stall counter not built.
`endif

endmodule

// File: tb/tb_dbuf_stream_writer.sv
// Self-checking bench for dbuf_stream_writer.
// Expected write addresses/data come from a frame-level model: every
// accepted word is written at its index within the frame, and a frame is
// clamp(cfg_len) words long. Timing of swaps and flags is checked at the
// points where the behaviour is defined.

module tb_dbuf_stream_writer;
    import dbuf_pkg::*;

    localparam int DW    = 64;
    localparam int AW    = 7;
    localparam int LW    = AW + 1;
    localparam int DEPTH = 128;
    localparam int EW    = AW + DW;

    logic          clk;
    logic          rst;
    logic [LW-1:0] cfg_len;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          wen;
    logic [AW-1:0] wadr;
    logic [DW-1:0] wdata;
    logic          switch_banks;
    logic          frame_valid;
    logic [LW-1:0] frame_len;
    logic          rd_done;
`ifdef DBUF_WR_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif
    wr_state_e     dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    int sw_cnt   = 0;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] obs_q[$];

    // Frame-level model: word index within the frame and the frame length.
    int m_idx = 0;
    int m_len = 0;

    dbuf_stream_writer #(
        .DATA_WIDTH      (DW),
        .BANK_ADDR_WIDTH (AW),
        .BANK_DEPTH      (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_len      (cfg_len),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .wen          (wen),
        .wadr         (wadr),
        .wdata        (wdata),
        .switch_banks (switch_banks),
        .frame_valid  (frame_valid),
        .frame_len    (frame_len),
        .rd_done      (rd_done),
`ifdef DBUF_WR_STALL_CNT_EN
        .stall_cnt    (stall_cnt),
`endif
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, checks %0d passed %0d", n_checks, n_pass);
        $fatal(1, "watchdog");
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (wen === 1'b1) obs_q.push_back({wadr, wdata});
        if (switch_banks === 1'b1) sw_cnt++;
    end

    // ---------------- model ----------------
    function automatic int clamp_ref(input int x);
        return (x == 0 || x > DEPTH) ? DEPTH : x;
    endfunction

    // Frame length is captured at the first word; tests keep cfg_len
    // unchanged between a load point and the following frame's first word.
    function automatic void model_accept(input logic [DW-1:0] d);
        logic [AW-1:0] a;
        if (m_idx == 0) m_len = clamp_ref(int'(cfg_len));
        a = AW'(m_idx);
        exp_q.push_back({a, d});
        m_idx++;
        if (m_idx == m_len) m_idx = 0;
    endfunction

    // ---------------- drivers ----------------
    // Called at posedge+1; returns at posedge+1 just after the handshake edge.
    task automatic send_word(input logic [DW-1:0] d);
        int waited;
        waited  = 0;
        s_valid = 1'b1;
        s_data  = d;
        @(negedge clk);
        while (!s_ready && waited < 300) begin
            waited++;
            @(negedge clk);
        end
        if (!s_ready) begin
            n_checks++;
            $display("FAIL send_timeout: s_ready=%b after %0d cycles, required 1", s_ready, waited);
        end else begin
            model_accept(d);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic idle_gap(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [DW-1:0] rnd_word();
        return {$urandom, $urandom};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b0; rd_done = 1'b0; cfg_len = 8'd4; s_data = '0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); @(negedge clk);
            n_checks++;
            if ({wen, switch_banks, frame_valid, s_ready} !== 4'b0000 || wadr !== '0 ||
                wdata !== '0 || frame_len !== '0)
                $display("FAIL reset_outputs: cycle %0d got wen=%b wadr=%0h wdata=%0h sw=%b fv=%b flen=%0d rdy=%b, required all 0",
                         c, wen, wadr, wdata, switch_banks, frame_valid, frame_len, s_ready);
            else n_pass++;
        end
`ifdef DBUF_WR_STALL_CNT_EN
        n_checks++;
        if (stall_cnt !== 16'd0) $display("FAIL reset_stall_cnt: got %0d required 0", stall_cnt);
        else n_pass++;
`endif
        @(posedge clk); #1;
        rst = 1'b0; m_idx = 0;
        @(negedge clk);
        n_checks++;
        if (s_ready !== 1'b1) $display("FAIL release_ready: got %b required 1", s_ready);
        else n_pass++;
        n_checks++;
        if (frame_valid !== 1'b0 || wen !== 1'b0)
            $display("FAIL release_idle: got fv=%b wen=%b required 0 0", frame_valid, wen);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_single_frame();
        for (int i = 0; i < 4; i++) send_word(64'hA0 + 64'(i));
        @(negedge clk);
        n_checks++;
        if (wen !== 1'b1 || wadr !== 7'd3 || wdata !== 64'hA3 || switch_banks !== 1'b0)
            $display("FAIL single_last_write: got wen=%b wadr=%0d wdata=%0h sw=%b required 1 3 a3 0",
                     wen, wadr, wdata, switch_banks);
        else n_pass++;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (switch_banks !== 1'b1 || frame_valid !== 1'b1 || frame_len !== 8'd4 || wen !== 1'b0)
            $display("FAIL single_swap: got sw=%b fv=%b flen=%0d wen=%b required 1 1 4 0",
                     switch_banks, frame_valid, frame_len, wen);
        else n_pass++;
        n_checks++;
        if (wadr !== 7'd3 || wdata !== 64'hA3)
            $display("FAIL single_hold: got wadr=%0d wdata=%0h required 3 a3", wadr, wdata);
        else n_pass++;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (switch_banks !== 1'b0) $display("FAIL single_pulse_width: got sw=%b required 0", switch_banks);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_pressure();
        int hold;
        int l3;
        logic [DW-1:0] w;
        hold = $urandom_range(3, 8);
        l3   = $urandom_range(1, 6);
        for (int i = 0; i < 4; i++) send_word(rnd_word());
        w = rnd_word();
        s_valid = 1'b1; s_data = w;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_checks++;
            if (s_ready !== 1'b0 || switch_banks !== 1'b0 || frame_valid !== 1'b1)
                $display("FAIL bp_hold: cycle %0d got rdy=%b sw=%b fv=%b required 0 0 1",
                         i, s_ready, switch_banks, frame_valid);
            else n_pass++;
            @(posedge clk); #1;
        end
        cfg_len = 8'(l3);
        rd_done = 1'b1;
        @(negedge clk);
        n_checks++;
        if (s_ready !== 1'b0 || switch_banks !== 1'b0)
            $display("FAIL bp_rd_done_cycle: got rdy=%b sw=%b required 0 0", s_ready, switch_banks);
        else n_pass++;
        @(posedge clk); #1;
        rd_done = 1'b0;
        @(negedge clk);
        n_checks++;
        if (switch_banks !== 1'b1 || frame_valid !== 1'b1 || frame_len !== 8'd4 || s_ready !== 1'b1)
            $display("FAIL bp_release: got sw=%b fv=%b flen=%0d rdy=%b required 1 1 4 1",
                     switch_banks, frame_valid, frame_len, s_ready);
        else n_pass++;
`ifdef DBUF_WR_STALL_CNT_EN
        n_checks++;
        if (stall_cnt !== 16'(hold + 1))
            $display("FAIL bp_stall_cnt: got %0d required %0d", stall_cnt, hold + 1);
        else n_pass++;
`endif
        // The held word transfers on the next edge.
        model_accept(w);
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (wen !== 1'b1 || wadr !== 7'd0 || wdata !== w)
            $display("FAIL bp_resume: got wen=%b wadr=%0d wdata=%0h required 1 0 %0h", wen, wadr, wdata, w);
        else n_pass++;
        @(posedge clk); #1;
        for (int i = 1; i < l3; i++) send_word(rnd_word());
    endtask

    task automatic test_simultaneous();
        int s0;
        s0 = sw_cnt;
        cfg_len = 8'($urandom_range(1, 8));
        rd_done = 1'b1;
        @(negedge clk);
        n_checks++;
        if (switch_banks !== 1'b0 || frame_valid !== 1'b1 || s_ready !== 1'b0)
            $display("FAIL sim_pre: got sw=%b fv=%b rdy=%b required 0 1 0", switch_banks, frame_valid, s_ready);
        else n_pass++;
        @(posedge clk); #1;
        rd_done = 1'b0;
        @(negedge clk);
        n_checks++;
        if (switch_banks !== 1'b1 || frame_valid !== 1'b1 || frame_len !== 8'(m_len))
            $display("FAIL sim_swap: got sw=%b fv=%b flen=%0d required 1 1 %0d",
                     switch_banks, frame_valid, frame_len, m_len);
        else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (sw_cnt - s0 !== 1 || frame_valid !== 1'b1)
            $display("FAIL sim_one_pulse: got pulses=%0d fv=%b required 1 1", sw_cnt - s0, frame_valid);
        else n_pass++;
    endtask

    task automatic test_rd_done();
        int s0;
        s0 = sw_cnt;
        rd_done = 1'b1;
        @(posedge clk); #1;
        rd_done = 1'b0;
        @(negedge clk);
        n_checks++;
        if (frame_valid !== 1'b0 || switch_banks !== 1'b0)
            $display("FAIL rd_done_clear: got fv=%b sw=%b required 0 0", frame_valid, switch_banks);
        else n_pass++;
        @(posedge clk); #1;
        rd_done = 1'b1;
        @(posedge clk); #1;
        rd_done = 1'b0;
        @(negedge clk);
        n_checks++;
        if (frame_valid !== 1'b0 || s_ready !== 1'b1 || sw_cnt !== s0)
            $display("FAIL rd_done_ignored: got fv=%b rdy=%b pulses=%0d required 0 1 0",
                     frame_valid, s_ready, sw_cnt - s0);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_clamp();
        rst = 1'b1; cfg_len = 8'd0;
        @(posedge clk); #1;
        rst = 1'b0; m_idx = 0;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < DEPTH; i++) begin
                idle_gap($urandom_range(0, 1));
                if (f == 1 && i == 10) rd_done = 1'b1;
                send_word(rnd_word());
                rd_done = 1'b0;
                if (f == 1 && i == 10) begin
                    @(negedge clk);
                    n_checks++;
                    if (frame_valid !== 1'b0) $display("FAIL clamp_rd_done: got fv=%b required 0", frame_valid);
                    else n_pass++;
                    @(posedge clk); #1;
                end
            end
            if (f == 0) cfg_len = 8'd200;
            @(negedge clk);
            n_checks++;
            if (wen !== 1'b1 || wadr !== 7'd127)
                $display("FAIL clamp_last_wadr: frame %0d got wen=%b wadr=%0d required 1 127", f, wen, wadr);
            else n_pass++;
            @(posedge clk); @(negedge clk);
            n_checks++;
            if (switch_banks !== 1'b1 || frame_valid !== 1'b1 || frame_len !== 8'd128)
                $display("FAIL clamp_swap: frame %0d got sw=%b fv=%b flen=%0d required 1 1 128",
                         f, switch_banks, frame_valid, frame_len);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mid_reset();
        int s0;
        logic [DW-1:0] w0;
        rst = 1'b1; cfg_len = 8'd4;
        @(posedge clk); #1;
        rst = 1'b0; m_idx = 0;
        s0 = sw_cnt;
        send_word(rnd_word());
        send_word(rnd_word());
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if ({wen, switch_banks, frame_valid, s_ready} !== 4'b0000 || wadr !== '0 || wdata !== '0 || frame_len !== '0)
            $display("FAIL mid_reset_outputs: got wen=%b sw=%b fv=%b rdy=%b wadr=%0d flen=%0d required all 0",
                     wen, switch_banks, frame_valid, s_ready, wadr, frame_len);
        else n_pass++;
`ifdef DBUF_WR_STALL_CNT_EN
        n_checks++;
        if (stall_cnt !== 16'd0) $display("FAIL mid_reset_stall_cnt: got %0d required 0", stall_cnt);
        else n_pass++;
`endif
        @(posedge clk); #1;
        rst = 1'b0; m_idx = 0;
        w0 = rnd_word();
        send_word(w0);
        @(negedge clk);
        n_checks++;
        if (wen !== 1'b1 || wadr !== 7'd0 || wdata !== w0)
            $display("FAIL mid_reset_restart: got wen=%b wadr=%0d wdata=%0h required 1 0 %0h", wen, wadr, wdata, w0);
        else n_pass++;
        @(posedge clk); #1;
        for (int i = 1; i < 4; i++) send_word(rnd_word());
        n_checks++;
        if (sw_cnt !== s0) $display("FAIL mid_reset_no_swap: got pulses=%0d required 0", sw_cnt - s0);
        else n_pass++;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (switch_banks !== 1'b1 || frame_len !== 8'd4 || frame_valid !== 1'b1)
            $display("FAIL mid_reset_swap: got sw=%b flen=%0d fv=%b required 1 4 1", switch_banks, frame_len, frame_valid);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_write_log();
        int n;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (obs_q.size() !== exp_q.size())
            $display("FAIL write_count: got %0d writes required %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i])
                $display("FAIL write_%0d: got adr=%0d data=%0h required adr=%0d data=%0h", i,
                         obs_q[i][EW-1:DW], obs_q[i][DW-1:0], exp_q[i][EW-1:DW], exp_q[i][DW-1:0]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_pressure();
        test_simultaneous();
        test_rd_done();
        test_clamp();
        test_mid_reset();
        test_write_log();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
